// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative multiply/divide sequencer, one bit per cycle
// Optional signed MULT/DIV support is enabled by defining MULDIV_SIGNED_EN.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Input1,
  input  logic [WIDTH-1:0] Input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t           state, state_next;
  logic [5:0]       cnt;
  logic             is_div;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] acc_next, q_next;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic             last_iter;

`ifdef MULDIV_SIGNED_EN
  logic               neg_res, neg_rem, b_zero;
  logic               a_neg_in, b_neg_in;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign a_neg_in = op[1] & Input1[WIDTH-1];
  assign b_neg_in = op[1] & Input2[WIDTH-1];

  // Operands are iterated as magnitudes; signs are reapplied on entry to DONE.
  always_comb begin
    mag_a = a_neg_in ? (~Input1 + 1'b1) : Input1;
    mag_b = b_neg_in ? (~Input2 + 1'b1) : Input2;
  end

  always_comb begin
    prod     = {acc_next, q_next};
    prod_neg = ~prod + 1'b1;
    hi_res   = acc_next;
    lo_res   = q_next;
    if (!is_div) begin
      if (neg_res) begin
        hi_res = prod_neg[2*WIDTH-1:WIDTH];
        lo_res = prod_neg[WIDTH-1:0];
      end
    end else begin
      // A zero divisor keeps the raw all-ones quotient regardless of signs.
      if (neg_res && !b_zero) lo_res = ~q_next + 1'b1;
      if (neg_rem)            hi_res = ~acc_next + 1'b1;
    end
  end
`else
  logic unused_op_msb;
  assign unused_op_msb = op[1];

  always_comb begin
    mag_a  = Input1;
    mag_b  = Input2;
    hi_res = acc_next;
    lo_res = q_next;
  end
`endif

  assign last_iter = (cnt == LAST);

  // Shared datapath: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum = {1'b0, acc} + {1'b0, (q[0] ? b : {WIDTH{1'b0}})};
    shifted = {acc, q[WIDTH-1]};
    borrow  = (shifted < {1'b0, b});
    diff    = shifted[WIDTH-1:0] - b;
    if (is_div) begin
      if (borrow) begin
        acc_next = shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = diff;
        q_next   = {q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = mul_sum[WIDTH:1];
      q_next   = {mul_sum[0], q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: state_next = start ? RUN : IDLE;
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      is_div <= 1'b0;
      acc    <= '0;
      q      <= '0;
      b      <= '0;
      HI     <= '0;
      LO     <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt    <= 6'd0;
            is_div <= op[0];
            acc    <= '0;
            q      <= mag_a;
            b      <= mag_b;
`ifdef MULDIV_SIGNED_EN
            neg_res <= a_neg_in ^ b_neg_in;
            neg_rem <= a_neg_in;
            b_zero  <= (Input2 == '0);
`endif
          end
        end
        RUN: begin
          acc <= acc_next;
          q   <= q_next;
          cnt <= cnt + 6'd1;
          if (last_iter) begin
            HI <= hi_res;
            LO <= lo_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard testbench for muldiv_sequencer
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] Input1, Input2;
  logic         busy, done;
  logic [W-1:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb_q[$];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .Input1(Input1), .Input2(Input2),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] bb);
    logic sgn;
    logic signed [W-1:0] sa, sb2, sq, sr;
    logic [2*W-1:0] p;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    sa = a;
    sb2 = bb;
    if (!o[0]) begin
      if (sgn) p = {{W{a[W-1]}}, a} * {{W{bb[W-1]}}, bb};
      else     p = {{W{1'b0}}, a} * {{W{1'b0}}, bb};
      return p;
    end
    if (bb == '0) return {a, {W{1'b1}}};
    if (sgn) begin
      sq = sa / sb2;
      sr = sa % sb2;
      return {sr, sq};
    end
    return {a % bb, a / bb};
  endfunction

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] bb);
    @(negedge clk);
    op = o; Input1 = a; Input2 = bb; start = 1'b1;
    sb_q.push_back(model(o, a, bb));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns edges from the start-sampling edge to the edge that samples done (-1 on timeout).
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = 2'b00; Input1 = 5; Input2 = 6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (HI !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", HI); end
    if (LO !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", LO); end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_multu;
    int lat, bc;
    logic [2*W-1:0] exp;
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc);
    exp = sb_q.pop_front();
    checks += 6;
    if (lat !== W + 1) begin errors++; $display("FAIL multu_latency: got %0d expected %0d", lat, W + 1); end
    if (bc !== W) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected %0d", bc, W); end
    if (HI !== exp[2*W-1:W]) begin errors++; $display("FAIL multu_hi: got %h expected %h", HI, exp[2*W-1:W]); end
    if (LO !== exp[W-1:0]) begin errors++; $display("FAIL multu_lo: got %h expected %h", LO, exp[W-1:0]); end
    if ({HI, LO} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_const: got %h expected fffffffe00000001", {HI, LO}); end
    @(negedge clk);
    if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_divu;
    logic [W-1:0] da[2] = '{32'd100, 32'd5};
    logic [W-1:0] db[2] = '{32'd7, 32'd0};
    logic [2*W-1:0] cst[2] = '{{32'd2, 32'd14}, {32'd5, 32'hFFFFFFFF}};
    int lat, bc;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      launch(2'b01, da[i], db[i]);
      wait_done(lat, bc);
      exp = sb_q.pop_front();
      checks += 3;
      if (lat !== W + 1) begin errors++; $display("FAIL divu_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
      if ({HI, LO} !== exp) begin errors++; $display("FAIL divu_result[%0d]: got %h expected %h", i, {HI, LO}, exp); end
      if ({HI, LO} !== cst[i]) begin errors++; $display("FAIL divu_const[%0d]: got %h expected %h", i, {HI, LO}, cst[i]); end
    end
  endtask

  task automatic test_signed_ops;
    int lat, bc;
    logic [2*W-1:0] exp, cst;
    launch(2'b11, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bc);
    exp = sb_q.pop_front();
`ifdef MULDIV_SIGNED_EN
    cst = {32'hFFFFFFFF, 32'hFFFFFFFD};
`else
    cst = {32'h00000001, 32'h7FFFFFFC};
`endif
    checks += 3;
    if (lat !== W + 1) begin errors++; $display("FAIL div_latency: got %0d expected %0d", lat, W + 1); end
    if ({HI, LO} !== exp) begin errors++; $display("FAIL div_result: got %h expected %h", {HI, LO}, exp); end
    if ({HI, LO} !== cst) begin errors++; $display("FAIL div_const: got %h expected %h", {HI, LO}, cst); end
    launch(2'b10, 32'hFFFFFFFD, 32'd4);
    wait_done(lat, bc);
    exp = sb_q.pop_front();
`ifdef MULDIV_SIGNED_EN
    cst = {32'hFFFFFFFF, 32'hFFFFFFF4};
`else
    cst = {32'h00000003, 32'hFFFFFFF4};
`endif
    checks += 2;
    if ({HI, LO} !== exp) begin errors++; $display("FAIL mult_result: got %h expected %h", {HI, LO}, exp); end
    if ({HI, LO} !== cst) begin errors++; $display("FAIL mult_const: got %h expected %h", {HI, LO}, cst); end
  endtask

  task automatic test_start_ignored;
    int lat, ndone;
    logic [2*W-1:0] exp;
    launch(2'b00, 32'd3, 32'd4);
    lat = -1;
    ndone = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 9) begin op = 2'b01; Input1 = 32'd9; Input2 = 32'd3; start = 1'b1; end
      if (n == 10) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n + 1;
          exp = sb_q.pop_front();
          checks++;
          if ({HI, LO} !== exp) begin errors++; $display("FAIL ignore_result: got %h expected %h", {HI, LO}, exp); end
        end
      end
    end
    checks += 2;
    if (lat !== W + 1) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, W + 1); end
    if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
  endtask

  task automatic test_hold;
    logic [W-1:0] hi0, lo0;
    hi0 = 32'd0;
    lo0 = 32'd12;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      op = 2'($urandom_range(0, 3)); Input1 = $urandom; Input2 = $urandom;
    end
    @(negedge clk);
    checks++;
    if ({HI, LO} !== {hi0, lo0}) begin errors++; $display("FAIL hold_result: got %h expected %h", {HI, LO}, {hi0, lo0}); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [2*W-1:0] exp;
    launch(2'b01, 32'd1000, 32'd33);
    wait_done(lat, bc);
    exp = sb_q.pop_front();
    checks++;
    if ({HI, LO} !== exp) begin errors++; $display("FAIL b2b_first: got %h expected %h", {HI, LO}, exp); end
    op = 2'b00; Input1 = 32'h12345678; Input2 = 32'h9ABCDEF0; start = 1'b1;
    sb_q.push_back(model(op, Input1, Input2));
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    exp = sb_q.pop_front();
    checks += 2;
    if (lat !== W + 1) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, W + 1); end
    if ({HI, LO} !== exp) begin errors++; $display("FAIL b2b_second: got %h expected %h", {HI, LO}, exp); end
  endtask

  task automatic test_reset_midrun;
    int lat, bc, ndone;
    logic [2*W-1:0] exp;
    launch(2'b01, 32'd100, 32'd7);
    void'(sb_q.pop_front());
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    if ({HI, LO} !== '0) begin errors++; $display("FAIL abort_result: got %h expected 0", {HI, LO}); end
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
    launch(2'b01, 32'd100, 32'd7);
    wait_done(lat, bc);
    exp = sb_q.pop_front();
    checks += 2;
    if (lat !== W + 1) begin errors++; $display("FAIL abort_restart_latency: got %0d expected %0d", lat, W + 1); end
    if ({HI, LO} !== exp) begin errors++; $display("FAIL abort_restart_result: got %h expected %h", {HI, LO}, exp); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [2*W-1:0] exp;
    logic [1:0] o;
    logic [W-1:0] a, bb;
    for (int i = 0; i < 8; i++) begin
      o = 2'(i % 4);
      a = $urandom;
      bb = (i == 5) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 70000)) : $urandom);
      launch(o, a, bb);
      wait_done(lat, bc);
      exp = sb_q.pop_front();
      checks++;
      if ({HI, LO} !== exp) begin errors++; $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, bb, {HI, LO}, exp); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; Input1 = '0; Input2 = '0;
    test_reset();
    test_multu();
    test_divu();
    test_signed_ops();
    test_start_ignored();
    test_hold();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
